tbec_scrubber: RTL and testbench
================================

Name: tbec_scrubber

Overview:
- Background memory scrubber that acts as the initiator on the tbec_full access interface (address, write data, write enable, read data, error code).
- Walks an address range. At each address it reads the word and checks the 2-bit error code.
- When the decoder reports a corrected error, it writes the corrected word back so single-event upsets do not accumulate.
- Sits between the host and tbec_full and yields the memory port to the host on request.

Parameters:
- ADDR_W, 8, address width; matches tbec_full address port.
- DATA_W, 16, data word width.
- RD_LAT, 2, cycles from address presented (mem_we=0) to valid mem_rdata/mem_err; must be ≥1.
- START_ADDR, 0, first address scrubbed.
- END_ADDR, 255, last address scrubbed (inclusive); must be ≥START_ADDR.
- CNT_W, 16, width of error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse: begin one full pass; ignored unless in IDLE.
- host_req  in  1  host wants the memory port.
- host_gnt  out  1  scrubber has released the memory port to the host.
- mem_addr  out  ADDR_W  address to tbec_full.
- mem_wdata  out  DATA_W  write data to tbec_full.
- mem_we  out  1  write enable to tbec_full.
- mem_rdata  in  DATA_W  corrected read data from tbec_full.
- mem_err  in  2  error code: 00 clean, 01 corrected, 10 uncorrectable, 11 treated as uncorrectable.
- busy  out  1  pass in progress, including HOLD.
- done  out  1  one-cycle pulse when a pass completes.
- corr_cnt  out  CNT_W  corrected-error count, saturating.
- uncorr_cnt  out  CNT_W  uncorrectable-error count, saturating.
- last_err_addr  out  ADDR_W  address of the most recent uncorrectable error.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - mem_addr=START_ADDR; mem_wdata=0; mem_we=0.
  - busy=0; done=0; host_gnt=1.
  - corr_cnt=0; uncorr_cnt=0; last_err_addr=0.
  - Reset mid-pass aborts immediately, with no write issued in the reset cycle.
- States:
  - IDLE: host_gnt=1. start=1 and host_req=0 → ISSUE with ptr=START_ADDR. start while host_req=1 is dropped.
  - ISSUE: host_gnt=0. If host_req=1 → HOLD. Otherwise drive mem_addr=ptr, mem_we=0, load wait counter=RD_LAT-1 → WAIT.
  - WAIT: hold mem_addr. When the counter reaches 0 → EVAL. host_req is ignored; the read-modify-write is atomic.
  - EVAL: sample mem_rdata/mem_err.
    - 00 → ADV.
    - 01 → corr_cnt+1, mem_wdata=mem_rdata → WB.
    - 10/11 → uncorr_cnt+1, last_err_addr=ptr → ADV. Never write back uncorrectable data.
  - WB: mem_we=1 for exactly one cycle with mem_addr=ptr → ADV.
  - ADV:
    - If ptr==END_ADDR: done=1 for one cycle → IDLE.
    - Else ptr+1 → ISSUE. If host_req=1 → HOLD instead, with ptr already advanced.
  - HOLD: host_gnt=1, mem_we=0. host_req=0 → ISSUE, resuming at the saved ptr.
- Each clean address takes 1 (ISSUE) + RD_LAT (WAIT) + 1 (EVAL) + 1 (ADV) cycles. A corrected address adds 1 cycle for WB.
- host_gnt changes only in ISSUE/ADV/HOLD/IDLE transitions, so the host never sees a half-done read-modify-write.
- mem_we is never 1 while host_gnt=1.
- Counters saturate at all-ones and are not cleared by start; only rst clears them.
- When START_ADDR==END_ADDR, a pass is a single address.
- ptr is never incremented past END_ADDR; there is no wrap to 0.
- busy=1 from the cycle after start is accepted until the done cycle inclusive; busy=0 in IDLE.

Optional Feature:
- Macro: TBEC_SCRUB_VERIFY_EN.
- Defined: after WB, add states VISSUE/VWAIT/VEVAL that re-read ptr with the same RD_LAT timing.
  - mem_err≠00 on the re-read → uncorr_cnt+1 and last_err_addr=ptr (stuck bit).
  - Then → ADV. host_req is ignored during the verify read.
- Undefined: WB goes directly to ADV; verify states are absent.

Test Plan:
- Reset: hold rst=0 for 2 cycles → all outputs at reset values, host_gnt=1, mem_we=0.
- Clean pass, START_ADDR=0, END_ADDR=3, RD_LAT=2, all reads 00 → four reads at addresses 0..3, no mem_we, done pulse 20 cycles after start accepted, counters stay 0.
- Corrected error: the bench memory returns mem_err=01 with data 16'hE1F0 at address 1 → exactly one mem_we pulse at addr 1 with mem_wdata=16'hE1F0, corr_cnt=1.
- Uncorrectable error: mem_err=10 at address 2 → no write, uncorr_cnt=1, last_err_addr=8'h02.
- Host preemption: assert host_req during WB of address 1 → WB completes, host_gnt=1 on the cycle after ADV, mem_we=0 while granted; release → scrubbing resumes at address 2.
- Reset mid-pass during WAIT at address 2, then start → pass restarts at address 0 with counters 0. With TBEC_SCRUB_VERIFY_EN and the re-read returning 01 → uncorr_cnt increments.

Source files
------------

// File: rtl/tbec_scrubber_if.sv
// Memory access bus between the scrubber (master) and tbec_full (slave).
// Latency: none, wires only; read data follows mem_addr after the memory's RD_LAT.
// Backpressure: none on the bus; port sharing with the host is arbitrated by the scrubber.
interface tbec_scrubber_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_err;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata,
    output mem_err
  );
endinterface

// File: rtl/tbec_scrubber.sv
// Background scrubber: reads START_ADDR..END_ADDR, writes back corrected words, counts errors.
// Latency: 3+RD_LAT cycles per clean address, +1 for write-back (+2+RD_LAT more with TBEC_SCRUB_VERIFY_EN).
// Backpressure: host_req parks the walk in HOLD between addresses; a read-modify-write is never split.
module tbec_scrubber #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 255,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_req,
  output logic              host_gnt,
  tbec_scrubber_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] last_err_addr
);

  // Wide enough to hold RD_LAT-1.
  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] FIRST     = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(END_ADDR);

`ifdef TBEC_SCRUB_VERIFY_EN
  typedef enum logic [3:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_WB, S_ADV, S_HOLD,
    S_VISSUE, S_VWAIT, S_VEVAL
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_WB, S_ADV, S_HOLD
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  uncorr_q, uncorr_d;
  logic [ADDR_W-1:0] last_q, last_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Register all walk state; reset returns to IDLE with counters cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= FIRST;
      wcnt_q   <= '0;
      addr_q   <= FIRST;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      last_q   <= last_d;
    end
  end

  // Next-state and datapath updates; mem_addr/mem_we are registered so they
  // change on the edge leaving ISSUE/EVAL and are stable for the whole cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !host_req) begin
          ptr_d   = FIRST;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (host_req) begin
          state_d = S_HOLD;
        end else begin
          addr_d  = ptr_q;
          wcnt_d  = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_EVAL;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      S_EVAL: begin
        if (mem.mem_err == 2'b00) begin
          state_d = S_ADV;
        end else if (mem.mem_err == 2'b01) begin
          corr_d  = sat_inc(corr_q);
          wdata_d = mem.mem_rdata;
          we_d    = 1'b1;
          state_d = S_WB;
        end else begin
          // Uncorrectable data is never written back.
          uncorr_d = sat_inc(uncorr_q);
          last_d   = ptr_q;
          state_d  = S_ADV;
        end
      end
      S_WB: begin
`ifdef TBEC_SCRUB_VERIFY_EN
        state_d = S_VISSUE;
`else
        state_d = S_ADV;
`endif
      end
`ifdef TBEC_SCRUB_VERIFY_EN
      S_VISSUE: begin
        wcnt_d  = WAIT_INIT;
        state_d = S_VWAIT;
      end
      S_VWAIT: begin
        if (wcnt_q == '0) state_d = S_VEVAL;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      S_VEVAL: begin
        // Any error right after a write-back means the bit is stuck.
        if (mem.mem_err != 2'b00) begin
          uncorr_d = sat_inc(uncorr_q);
          last_d   = ptr_q;
        end
        state_d = S_ADV;
      end
`endif
      S_ADV: begin
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = host_req ? S_HOLD : S_ISSUE;
        end
      end
      S_HOLD: begin
        if (!host_req) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign host_gnt = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_ADV) && (ptr_q == LAST);

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  // A reset arriving during WB suppresses the write in that same cycle.
  assign mem.mem_we    = we_q && rst;

  assign corr_cnt      = corr_q;
  assign uncorr_cnt    = uncorr_q;
  assign last_err_addr = last_q;

endmodule

// File: tb/tb_tbec_scrubber.sv
// Directed bench for tbec_scrubber over addresses 0..3 with a RD_LAT=2 memory model.
// Latency: expected done cycles are hand-derived (5 per clean address, +1 WB, +VX verify).
// Backpressure: host_req is driven on chosen cycles to exercise HOLD.
module tb_tbec_scrubber;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
`ifdef TBEC_SCRUB_VERIFY_EN
  localparam int VX = 4;
`else
  localparam int VX = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic host_req = 1'b0;
  logic host_gnt, busy, done;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic [ADDR_W-1:0] last_err_addr;

  tbec_scrubber_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  tbec_scrubber #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2),
    .START_ADDR(0), .END_ADDR(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .host_req(host_req),
    .host_gnt(host_gnt), .mem(mif), .busy(busy), .done(done),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  // Memory model: two-stage address pipeline gives RD_LAT=2; a write-back
  // clears the error at that address unless it is marked stuck.
  logic [15:0] mdat [256];
  logic [1:0]  merr [256];
  logic        stuck [256];
  logic        fixed [256];
  logic        clr_fixed = 1'b0;
  logic [7:0]  a1, a2;

  always @(posedge clk) begin
    if (!rst) begin
      a1 <= '0;
      a2 <= '0;
    end else begin
      a1 <= mif.mem_addr;
      a2 <= a1;
    end
    if (clr_fixed) begin
      for (int i = 0; i < 256; i++) fixed[i] <= 1'b0;
    end else if (mif.mem_we && !stuck[mif.mem_addr]) begin
      fixed[mif.mem_addr] <= 1'b1;
    end
  end

  assign mif.mem_rdata = mdat[a2];
  assign mif.mem_err   = fixed[a2] ? 2'b00 : merr[a2];

  int n_chk  = 0;
  int n_pass = 0;

  int          wr_cnt, wr_cyc, viol;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  addr_log [0:255];
  logic        gnt_log  [0:255];
  logic        busy_log [0:255];

  task automatic set_mem_clean();
    for (int i = 0; i < 256; i++) begin
      mdat[i]  = 16'h1000 + 16'(i);
      merr[i]  = 2'b00;
      stuck[i] = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    clr_fixed = 1'b1;
    @(negedge clk);
    clr_fixed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one pass, logging per-cycle outputs; cycle k is sampled at the
  // negedge after the k-th rising edge following start acceptance.
  task automatic run_pass(input int hon, input int hoff, output int dcyc);
    wr_cnt = 0; wr_cyc = -1; viol = 0; wr_addr = '0; wr_data = '0;
    dcyc = -1;
    pulse_start();
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      addr_log[k] = mif.mem_addr;
      gnt_log[k]  = host_gnt;
      busy_log[k] = busy;
      if (mif.mem_we) begin
        wr_cnt++; wr_cyc = k; wr_addr = mif.mem_addr; wr_data = mif.mem_wdata;
      end
      if (mif.mem_we && host_gnt) viol++;
      host_req = (k >= hon) && (k < hoff);
      if (done) begin
        dcyc = k;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (host_gnt !== 1'b1) $display("FAIL rst_gnt got %b want 1", host_gnt); else n_pass++;
    n_chk++; if (mif.mem_we !== 1'b0) $display("FAIL rst_we got %b want 0", mif.mem_we); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd0) $display("FAIL rst_corr got %0d want 0", corr_cnt); else n_pass++;
    n_chk++; if (uncorr_cnt !== 16'd0) $display("FAIL rst_uncorr got %0d want 0", uncorr_cnt); else n_pass++;
    n_chk++; if (last_err_addr !== 8'h00) $display("FAIL rst_last got %h want 00", last_err_addr); else n_pass++;
    n_chk++; if (mif.mem_addr !== 8'h00) $display("FAIL rst_addr got %h want 00", mif.mem_addr); else n_pass++;
    n_chk++; if (mif.mem_wdata !== 16'h0000) $display("FAIL rst_wdata got %h want 0000", mif.mem_wdata); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_clean_pass();
    int d;
    set_mem_clean();
    run_pass(0, 0, d);
    n_chk++; if (d !== 20) $display("FAIL clean_done_cyc got %0d want 20", d); else n_pass++;
    n_chk++; if (wr_cnt !== 0) $display("FAIL clean_writes got %0d want 0", wr_cnt); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      n_chk++;
      if (addr_log[5*a+2] !== 8'(a)) $display("FAIL clean_addr%0d got %h want %h", a, addr_log[5*a+2], 8'(a));
      else n_pass++;
    end
    n_chk++; if (busy_log[1] !== 1'b1) $display("FAIL clean_busy_first got %b want 1", busy_log[1]); else n_pass++;
    n_chk++; if (busy_log[20] !== 1'b1) $display("FAIL clean_busy_done got %b want 1", busy_log[20]); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0)
      $display("FAIL clean_cnts got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL clean_after got done=%b busy=%b want 0 0", done, busy); else n_pass++;
  endtask

  task automatic test_corrected();
    int d;
    set_mem_clean();
    merr[1] = 2'b01; mdat[1] = 16'hE1F0;
    run_pass(0, 0, d);
    n_chk++; if (d !== 21 + VX) $display("FAIL corr_done_cyc got %0d want %0d", d, 21 + VX); else n_pass++;
    n_chk++; if (wr_cnt !== 1) $display("FAIL corr_writes got %0d want 1", wr_cnt); else n_pass++;
    n_chk++; if (wr_addr !== 8'h01) $display("FAIL corr_wr_addr got %h want 01", wr_addr); else n_pass++;
    n_chk++; if (wr_data !== 16'hE1F0) $display("FAIL corr_wr_data got %h want e1f0", wr_data); else n_pass++;
    n_chk++; if (wr_cyc !== 10) $display("FAIL corr_wr_cyc got %0d want 10", wr_cyc); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd1) $display("FAIL corr_cnt got %0d want 1", corr_cnt); else n_pass++;
    n_chk++; if (uncorr_cnt !== 16'd0) $display("FAIL corr_uncorr got %0d want 0", uncorr_cnt); else n_pass++;
  endtask

  task automatic test_uncorrectable();
    int d;
    set_mem_clean();
    merr[2] = 2'b10;
    run_pass(0, 0, d);
    n_chk++; if (d !== 20) $display("FAIL unc_done_cyc got %0d want 20", d); else n_pass++;
    n_chk++; if (wr_cnt !== 0) $display("FAIL unc_writes got %0d want 0", wr_cnt); else n_pass++;
    n_chk++; if (uncorr_cnt !== 16'd1) $display("FAIL unc_cnt got %0d want 1", uncorr_cnt); else n_pass++;
    n_chk++; if (last_err_addr !== 8'h02) $display("FAIL unc_last got %h want 02", last_err_addr); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd1) $display("FAIL unc_corr_kept got %0d want 1", corr_cnt); else n_pass++;
  endtask

  task automatic test_err11();
    int d;
    set_mem_clean();
    merr[3] = 2'b11;
    run_pass(0, 0, d);
    n_chk++; if (wr_cnt !== 0) $display("FAIL e11_writes got %0d want 0", wr_cnt); else n_pass++;
    n_chk++; if (uncorr_cnt !== 16'd2) $display("FAIL e11_cnt got %0d want 2", uncorr_cnt); else n_pass++;
    n_chk++; if (last_err_addr !== 8'h03) $display("FAIL e11_last got %h want 03", last_err_addr); else n_pass++;
  endtask

  task automatic test_start_while_host();
    @(negedge clk);
    host_req = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL drop_start_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (host_gnt !== 1'b1) $display("FAIL drop_start_gnt got %b want 1", host_gnt); else n_pass++;
    host_req = 1'b0;
  endtask

  task automatic test_host_preempt();
    int d;
    set_mem_clean();
    merr[1] = 2'b01; mdat[1] = 16'hE1F0;
    run_pass(10, 15 + VX, d);
    n_chk++; if (wr_cnt !== 1 || wr_cyc !== 10)
      $display("FAIL pre_wb got cnt=%0d cyc=%0d want 1 10", wr_cnt, wr_cyc); else n_pass++;
    n_chk++; if (gnt_log[11+VX] !== 1'b0) $display("FAIL pre_gnt_adv got %b want 0", gnt_log[11+VX]); else n_pass++;
    n_chk++; if (gnt_log[12+VX] !== 1'b1) $display("FAIL pre_gnt_hold got %b want 1", gnt_log[12+VX]); else n_pass++;
    n_chk++; if (viol !== 0) $display("FAIL pre_we_gnt got %0d want 0", viol); else n_pass++;
    n_chk++; if (addr_log[17+VX] !== 8'h02) $display("FAIL pre_resume got %h want 02", addr_log[17+VX]); else n_pass++;
    n_chk++; if (d !== 25 + VX) $display("FAIL pre_done_cyc got %0d want %0d", d, 25 + VX); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd2) $display("FAIL pre_corr got %0d want 2", corr_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_pass();
    int d;
    set_mem_clean();
    merr[0] = 2'b01;
    merr[1] = 2'b10;
    pulse_start();
    for (int k = 1; k <= 13 + VX; k++) @(negedge clk);
    n_chk++; if (mif.mem_addr !== 8'h02 || corr_cnt !== 16'd3 || uncorr_cnt !== 16'd3)
      $display("FAIL mid_pre got addr=%h corr=%0d unc=%0d want 02 3 3", mif.mem_addr, corr_cnt, uncorr_cnt);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || host_gnt !== 1'b1)
      $display("FAIL mid_rst_state got busy=%b gnt=%b want 0 1", busy, host_gnt); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0 || last_err_addr !== 8'h00)
      $display("FAIL mid_rst_cnts got %0d %0d %h want 0 0 00", corr_cnt, uncorr_cnt, last_err_addr); else n_pass++;
    rst = 1'b1;
    set_mem_clean();
    run_pass(0, 0, d);
    n_chk++; if (d !== 20) $display("FAIL mid_restart_done got %0d want 20", d); else n_pass++;
    n_chk++; if (addr_log[2] !== 8'h00) $display("FAIL mid_restart_addr got %h want 00", addr_log[2]); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0)
      $display("FAIL mid_restart_cnts got %0d %0d want 0 0", corr_cnt, uncorr_cnt); else n_pass++;
  endtask

  task automatic test_reset_in_wb();
    set_mem_clean();
    merr[1] = 2'b01;
    pulse_start();
    for (int k = 1; k <= 10; k++) @(negedge clk);
    n_chk++; if (mif.mem_we !== 1'b1) $display("FAIL rwb_we_before got %b want 1", mif.mem_we); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (mif.mem_we !== 1'b0) $display("FAIL rwb_we_in_rst got %b want 0", mif.mem_we); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || mif.mem_we !== 1'b0)
      $display("FAIL rwb_after got busy=%b we=%b want 0 0", busy, mif.mem_we); else n_pass++;
    rst = 1'b1;
  endtask

`ifdef TBEC_SCRUB_VERIFY_EN
  task automatic test_verify_stuck();
    int d;
    set_mem_clean();
    merr[1] = 2'b01;
    stuck[1] = 1'b1;
    run_pass(0, 0, d);
    n_chk++; if (d !== 25) $display("FAIL vfy_done_cyc got %0d want 25", d); else n_pass++;
    n_chk++; if (corr_cnt !== 16'd1) $display("FAIL vfy_corr got %0d want 1", corr_cnt); else n_pass++;
    n_chk++; if (uncorr_cnt !== 16'd1) $display("FAIL vfy_uncorr got %0d want 1", uncorr_cnt); else n_pass++;
    n_chk++; if (last_err_addr !== 8'h01) $display("FAIL vfy_last got %h want 01", last_err_addr); else n_pass++;
  endtask
`endif

  initial begin
    set_mem_clean();
    test_reset();
    test_clean_pass();
    test_corrected();
    test_uncorrectable();
    test_err11();
    test_start_while_host();
    test_host_preempt();
    test_reset_mid_pass();
    test_reset_in_wb();
`ifdef TBEC_SCRUB_VERIFY_EN
    test_verify_stuck();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
